morse_keyer: RTL

Parametrised on-off-keying sequencer that generalises the joystick-gated carrier keying in our iCE40 top level. Encoded Morse symbols are queued through a FIFO written from the SPI command path. The block emits a timed `key` level with dot, dash and gap durations derived from a run-time unit length. `key` gates the DDR carrier SB_IO and the status LED; a manual key input keeps the existing push-to-key behaviour.

---
 rtl/morse_keyer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/morse_keyer.sv
`timescale 1ns/1ps
// morse_keyer: queued Morse on-off-keying sequencer.
// Symbol bytes enter a FIFO. A three-process FSM pops them and times the
// dot/dash marks, the element and character gaps, and the word gaps in units
// of a latched unit length. The manual straight key is ORed into the output.
module morse_keyer #(
    parameter  int UNIT_W = 24,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int LW     = AW + 1
) (
    input  logic              clk,
    input  logic              resetq,
    input  logic [UNIT_W-1:0] unit_len,
    input  logic [7:0]        wr_data,
    input  logic              wr_stb,
    input  logic              flush,
    input  logic              manual_key,
    output logic              key,
    output logic              busy,
    output logic              full,
    output logic [LW-1:0]     level,
    output logic              overflow
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MARK   = 3'd1,
        S_ESPACE = 3'd2,
        S_CGAP   = 3'd3,
        S_WGAP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]        r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_overflow;
    logic              r_manual;

    // Sequencer state
    state_t            r_state;
    state_t            w_state_next;
    state_t            w_pop_target;
    logic [UNIT_W-1:0] r_unit_len;
    logic [UNIT_W-1:0] r_unit_cnt;
    logic [2:0]        r_units;
    logic [2:0]        r_elem;
    logic [2:0]        r_count;
    logic [7:0]        r_pattern;

    logic [7:0]        w_head;
    logic [2:0]        w_head_n;
    logic [UNIT_W-1:0] w_u_new;
    logic              w_fifo_empty;
    logic              w_full;
    logic              w_wr_ok;
    logic              w_wr_drop;
    logic              w_pop;
    logic              w_phase_done;
    logic              w_more_elems;
    logic              w_gap_state;

    assign w_head       = r_mem[r_rd_ptr];
    // Element counts of 6 and 7 are treated as 5.
    assign w_head_n     = (w_head[7:5] > 3'd5) ? 3'd5 : w_head[7:5];
    // A unit length of zero would stall the counter, so it runs as one cycle.
    assign w_u_new      = (unit_len == '0) ? UNIT_W'(1) : unit_len;
    assign w_fifo_empty = (r_level == '0);
    assign w_full       = (r_level == LW'(DEPTH));
    // Flush swallows a simultaneous write without flagging overflow.
    assign w_wr_ok      = wr_stb & ~flush & ~w_full;
    assign w_wr_drop    = wr_stb & ~flush & w_full;
    // A phase of K units ends when both the cycle and unit counters are spent.
    assign w_phase_done = (r_unit_cnt == '0) && (r_units == 3'd0);
    assign w_more_elems = ((r_elem + 3'd1) < r_count);
    assign w_gap_state  = (r_state == S_CGAP) || (r_state == S_WGAP);
    // Pops are decided on the registered level, so a write into an empty
    // FIFO can never be popped in the same cycle.
    assign w_pop        = ~flush & ~w_fifo_empty &
                          ((r_state == S_IDLE) | (w_gap_state & w_phase_done));
    assign w_pop_target = (w_head_n == 3'd0) ? S_WGAP : S_MARK;

    // FIFO memory write port (no reset so it maps onto RAM)
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= r_level + LW'(w_wr_ok) - LW'(w_pop);
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Manual key passes through a single synchronising flop
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_manual <= 1'b0;
        end else begin
            r_manual <= manual_key;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        w_state_next = w_pop_target;
                    end
                end
                S_MARK: begin
                    if (w_phase_done) begin
                        w_state_next = w_more_elems ? S_ESPACE : S_CGAP;
                    end
                end
                S_ESPACE: begin
                    if (w_phase_done) begin
                        w_state_next = S_MARK;
                    end
                end
                S_CGAP, S_WGAP: begin
                    if (w_phase_done) begin
                        w_state_next = w_pop ? w_pop_target : S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Duration counters, symbol latch and element sequencing
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_unit_len <= '0;
            r_unit_cnt <= '0;
            r_units    <= 3'd0;
            r_elem     <= 3'd0;
            r_count    <= 3'd0;
            r_pattern  <= 8'd0;
        end else if (flush) begin
            r_unit_cnt <= '0;
            r_units    <= 3'd0;
            r_elem     <= 3'd0;
        end else if (w_pop) begin
            // Unit length is sampled here and held for the whole symbol.
            r_unit_len <= w_u_new;
            r_unit_cnt <= w_u_new - UNIT_W'(1);
            r_count    <= w_head_n;
            r_pattern  <= {3'b000, w_head[4:0]};
            r_elem     <= 3'd0;
            // r_units holds the units left after the current one.
            if (w_head_n == 3'd0) begin
                r_units <= 3'd3;
            end else begin
                r_units <= w_head[0] ? 3'd2 : 3'd0;
            end
        end else if (r_state != S_IDLE) begin
            if (!w_phase_done) begin
                if (r_unit_cnt != '0) begin
                    r_unit_cnt <= r_unit_cnt - UNIT_W'(1);
                end else begin
                    r_unit_cnt <= r_unit_len - UNIT_W'(1);
                    r_units    <= r_units - 3'd1;
                end
            end else begin
                r_unit_cnt <= r_unit_len - UNIT_W'(1);
                case (r_state)
                    S_MARK: begin
                        if (w_more_elems) begin
                            r_elem  <= r_elem + 3'd1;
                            r_units <= 3'd0;
                        end else begin
                            r_units <= 3'd2;
                        end
                    end
                    S_ESPACE: r_units <= r_pattern[r_elem] ? 3'd2 : 3'd0;
                    default:  r_units <= 3'd0;
                endcase
            end
        end
    end

    // Outputs derived directly from registered state
    always_comb begin
        key      = (r_state == S_MARK) | r_manual;
        busy     = (r_state != S_IDLE) | ~w_fifo_empty;
        full     = w_full;
        level    = r_level;
        overflow = r_overflow;
    end

endmodule
